// File: rtl/clk_gen_param.sv
// Power-of-two clock divider tree with rate strobes, a glitch-free selectable
// output clock, and a synchronous realign input that drives a lock indicator.
module clk_gen_param #(
  parameter int DIV_STAGES = 5,
  parameter int SEL_W      = 3
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [SEL_W-1:0]      sel,
  output logic [DIV_STAGES-1:0] clk_div,
  output logic [DIV_STAGES-1:0] stb,
  output logic                  clk_out,
  output logic [SEL_W-1:0]      sel_active,
  output logic                  locked
);

  localparam int SRC_N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(DIV_STAGES - 1);

  logic [DIV_STAGES-1:0] cnt_q, cnt_d, cnt_next;
  logic [DIV_STAGES-1:0] div_q, div_d;
  logic [DIV_STAGES-1:0] stb_q, stb_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  out_q, out_d;
  logic                  lock_q, lock_d;
  logic                  wrap;
  logic [SRC_N-1:0]      src;

  // Sources beyond the last stage stay zero, so an out-of-range select gates
  // clk_out off without a separate compare.
  always_comb begin
    cnt_next = cnt_q + DIV_STAGES'(1);
    wrap     = (cnt_next == '0);
    sel_d    = sel_q;
    if (clear || wrap) sel_d = sel;
    src                   = '0;
    src[DIV_STAGES-1:0]   = cnt_next;
    cnt_d  = cnt_next;
    div_d  = cnt_next;
    stb_d  = ~cnt_q & cnt_next;
    out_d  = src[sel_d];
    lock_d = lock_q | wrap;
    if (clear) begin
      cnt_d  = '0;
      div_d  = '0;
      stb_d  = '0;
      out_d  = 1'b0;
      lock_d = 1'b0;
    end
  end

  // Select only moves at the wrap, when every divided clock is low, so the
  // new source always starts a fresh full half-period.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      div_q  <= '0;
      stb_q  <= '0;
      sel_q  <= SEL_RST;
      out_q  <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      stb_q  <= stb_d;
      sel_q  <= sel_d;
      out_q  <= out_d;
      lock_q <= lock_d;
    end
  end

  assign clk_div    = div_q;
  assign stb        = stb_q;
  assign clk_out    = out_q;
  assign sel_active = sel_q;
  assign locked     = lock_q;

endmodule

// File: doc/clk_gen_param.md
# clk_gen_param

Parametrised clock-divider generator for the PHY clocking tree. It derives `DIV_STAGES` power-of-two divided clocks from the fast `clk_32f` reference, so the default configuration reproduces clk_16f, clk_8f, clk_4f, clk_2f and clk_f. It adds three things: single-cycle rate strobes for clock-enable style logic, a glitch-free programmable output clock, and a synchronous realignment input with a lock indicator. It sits at the root of the PHY clock domain and feeds the serializer and deserializer lanes.

## Interface
- `DIV_STAGES`, default 5: number of divide-by-two stages; output i runs at clk_32f / 2^(i+1). Legal range 1..8.
- `SEL_W`, default 3: width of `sel`; must satisfy 2^SEL_W > DIV_STAGES.
- `clk_32f`  in  1  sole clock; all flops sample on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 forces every register to its reset value immediately.
- `clear`  in  1  synchronous realign request, active high.
- `sel`  in  SEL_W  requested source for `clk_out`.
- `clk_div`  out  DIV_STAGES  divided clocks, 50% duty; bit i has period 2^(i+1) clk_32f cycles.
- `stb`  out  DIV_STAGES  one-cycle pulse coincident with each rising edge of `clk_div[i]`.
- `clk_out`  out  1  selected divided clock, switched glitch-free.
- `sel_active`  out  SEL_W  source currently driving `clk_out`.
- `locked`  out  1  high once all divided clocks have completed a full aligned period.

## Operation
- Core is a DIV_STAGES-bit up-counter `cnt` that increments every clk_32f edge and wraps from 2^DIV_STAGES-1 to 0.
- `clk_div[i]` is the registered value of `cnt[i]`, taken directly from the flop with no combinational path.
- `stb[i]` is registered and equals 1 exactly in the cycles where `cnt[i]` has just gone 0->1.
- Select handling:
  - `sel_active` loads `sel` only on the edge where `cnt` wraps to 0, when every divided clock is low. Between wraps, `sel` changes are ignored; only the value present at the wrap edge is taken.
  - `clk_out` is a flop loaded with `cnt_next[sel_next]`.
  - When `sel_active` >= DIV_STAGES, `clk_out` is held at 0 (gated off).
- `locked` rises on the first wrap to 0 after reset or clear and then stays high.
- `clear` has priority over counting. On the next edge:
  - `cnt`, `clk_div`, `stb` and `clk_out` go to 0;
  - `locked` goes to 0;
  - `sel_active` loads `sel` immediately.
  Counting resumes on the following edge.
- If `clear` is held for several cycles, all of the above stay at 0 and `sel_active` tracks `sel` every cycle.
- Reset values: `cnt`=0, `clk_div`=0, `stb`=0, `clk_out`=0, `locked`=0, `sel_active`=DIV_STAGES-1 (slowest clock).

## Timing
- Edge k is the k-th rising edge after `reset` deasserts; the first edge gives `cnt`=1.
- After edge k, `cnt` = k mod 2^DIV_STAGES and `clk_div[i]` = bit i of that value. The first rising edge of `clk_div[i]` occurs at edge 2^i.
- `stb[i]` is high after edges 2^i, 2^i + 2^(i+1), and so on, for exactly one cycle each.
- `clk_out` latency is zero relative to `clk_div`: it toggles on the same edge as the selected `clk_div` bit.
- A select change takes effect at the wrap edge. From the cycle after that edge, `clk_out` follows the new source with no runt pulse: the first high phase is a full half-period of the new clock.
- `locked` rises at edge 2^DIV_STAGES after reset, or 2^DIV_STAGES edges after `clear` is released.
- Reset asserted mid-operation clears all outputs asynchronously, with no dependence on the clock.
- If `sel` changes in the same cycle as the wrap, the value sampled at that edge is the one applied.

## Test plan
- Default params, reset released, `sel`=4 -> `clk_div[0]` period 2, `clk_div[4]` period 32 cycles; `clk_out` equals `clk_div[4]`; `locked` rises at edge 32.
- Count `stb[2]` pulses over 64 cycles -> exactly 8 pulses, each one cycle wide and aligned with the rising edges of `clk_div[2]`.
- `sel` changes 4->1 at edge 40 -> `sel_active` updates at edge 64; `clk_out` stays low until edge 65, then toggles every 2 cycles; no high pulse shorter than 1 or 2 cycles is observed.
- `sel`=6 with `DIV_STAGES`=5 -> after the next wrap, `clk_out` is constantly 0 and `sel_active` reads 6.
- `clear` pulsed for one cycle at edge 50 -> at edge 51 all `clk_div`, `stb` and `locked` are 0; `cnt` restarts; `locked` rises 32 edges later.
- `reset` driven to 0 between clock edges at cycle 20 -> all outputs go to 0 immediately; after release the sequence repeats exactly as in the first scenario.
